// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bundle between the fetch stage (master)
// and the instruction memory (slave).
interface if_fetch_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ready_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ready_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency imem over
// req/ready, and feeds IF/ID one instruction (or a NOP bubble) per cycle.
module if_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hazard_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    if_fetch_if.master  imem,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        flush_o
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_r,     pc_d;
    logic [31:0] addr_r,   addr_d;
    logic [31:0] buf_r,    buf_d;
    logic [31:0] buf_pc_r, buf_pc_d;

    logic        req_c;
    logic [31:0] addr_c;
    logic [31:0] instr_c;
    logic [31:0] pc_out_c;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_REQ;
            pc_r     <= RESET_PC;
            addr_r   <= RESET_PC;
            buf_r    <= '0;
            buf_pc_r <= '0;
        end else begin
            state_q  <= state_d;
            pc_r     <= pc_d;
            addr_r   <= addr_d;
            buf_r    <= buf_d;
            buf_pc_r <= buf_pc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_r;
        addr_d   = addr_r;
        buf_d    = buf_r;
        buf_pc_d = buf_pc_r;
        req_c    = 1'b0;
        addr_c   = pc_r;
        instr_c  = NOP_INSTR;
        pc_out_c = '0;

        unique case (state_q)
            S_REQ: begin
                req_c  = 1'b1;
                addr_c = pc_r;
                // addr_r tracks the live request so a redirect can keep it for DRAIN
                addr_d = pc_r;
                if (branch_i) begin
                    pc_d = branch_target_i;
                    if (!imem.imem_ready_i) begin
                        state_d = S_DRAIN;
                    end
                end else if (imem.imem_ready_i) begin
                    instr_c  = imem.imem_rdata_i;
                    pc_out_c = pc_r;
                    pc_d     = pc_r + 32'd4;
                    if (hazard_i) begin
                        buf_d    = imem.imem_rdata_i;
                        buf_pc_d = pc_r;
                        state_d  = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (branch_i) begin
                    pc_d    = branch_target_i;
                    addr_d  = branch_target_i;
                    state_d = S_REQ;
                end else begin
                    instr_c  = buf_r;
                    pc_out_c = buf_pc_r;
                    if (!hazard_i) begin
                        addr_d  = pc_r;
                        state_d = S_REQ;
                    end
                end
            end

            S_DRAIN: begin
                req_c  = 1'b1;
                addr_c = addr_r;
                if (branch_i) begin
                    pc_d = branch_target_i;
                end
                if (imem.imem_ready_i) begin
                    addr_d  = pc_d;
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_comb begin
        imem.imem_req_o  = rst_i ? 1'b0 : req_c;
        imem.imem_addr_o = addr_c;
        instr_o          = rst_i ? NOP_INSTR : instr_c;
        pc_o             = rst_i ? '0 : pc_out_c;
        flush_o          = rst_i ? 1'b0 : branch_i;
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus randomized traffic, checked
// against a transaction-level model of the fetch stage.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_i, hazard_i, branch_i;
    logic [31:0] branch_target_i;
    logic [31:0] pc_o, instr_o;
    logic        flush_o;

    logic        rst2_i;
    logic [31:0] pc2_o, instr2_o;
    logic        flush2_o;

    int total = 0;
    int bad   = 0;

    if_fetch_if imem ();
    if_fetch_if imem2 ();

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .hazard_i        (hazard_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .imem            (imem),
        .pc_o            (pc_o),
        .instr_o         (instr_o),
        .flush_o         (flush_o)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) dut2 (
        .clk_i           (clk),
        .rst_i           (rst2_i),
        .hazard_i        (1'b0),
        .branch_i        (1'b0),
        .branch_target_i (32'h0),
        .imem            (imem2),
        .pc_o            (pc2_o),
        .instr_o         (instr2_o),
        .flush_o         (flush2_o)
    );

    // Reference model: the PC to fetch next, an optional abandoned request
    // whose response must be thrown away, and an optional parked instruction.
    logic [31:0] m_pc;
    logic        m_stale;
    logic [31:0] m_stale_addr;
    logic        m_held;
    logic [31:0] m_held_word, m_held_pc;

    logic        s_req, s_flush;
    logic [31:0] s_addr, s_pc, s_instr;
    logic        s2_req;
    logic [31:0] s2_addr, s2_pc, s2_instr;

    logic        r2_rst, r2_rdy;
    logic [31:0] r2_word;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic hz, input logic br,
                        input logic [31:0] tgt, input logic rdy);
        logic        e_req, e_flush;
        logic [31:0] e_addr, e_pc, e_instr, rd;

        e_addr = m_stale ? m_stale_addr : m_pc;
        rd     = mem_word(e_addr);

        rst_i             = rst;
        hazard_i          = hz;
        branch_i          = br;
        branch_target_i   = tgt;
        imem.imem_ready_i = rdy;
        imem.imem_rdata_i = rd;
        rst2_i             = r2_rst;
        imem2.imem_ready_i = r2_rdy;
        imem2.imem_rdata_i = r2_word;

        e_req   = 1'b1;
        e_flush = br;
        e_pc    = 32'h0;
        e_instr = 32'h0;
        if (rst) begin
            e_req   = 1'b0;
            e_flush = 1'b0;
        end else if (m_held) begin
            e_req = 1'b0;
            if (!br) begin
                e_pc    = m_held_pc;
                e_instr = m_held_word;
            end
        end else if (!m_stale && rdy && !br) begin
            e_pc    = m_pc;
            e_instr = rd;
        end

        @(negedge clk);
        s_req    = imem.imem_req_o;
        s_addr   = imem.imem_addr_o;
        s_pc     = pc_o;
        s_instr  = instr_o;
        s_flush  = flush_o;
        s2_req   = imem2.imem_req_o;
        s2_addr  = imem2.imem_addr_o;
        s2_pc    = pc2_o;
        s2_instr = instr2_o;

        chk("req",   {31'd0, s_req},   {31'd0, e_req});
        chk("flush", {31'd0, s_flush}, {31'd0, e_flush});
        chk("pc",    s_pc,    e_pc);
        chk("instr", s_instr, e_instr);
        if (e_req) chk("addr", s_addr, e_addr);

        @(posedge clk);
        if (rst) begin
            m_pc    = 32'h0;
            m_stale = 1'b0;
            m_held  = 1'b0;
        end else if (m_held) begin
            if (br) begin
                m_held = 1'b0;
                m_pc   = tgt;
            end else if (!hz) begin
                m_held = 1'b0;
            end
        end else if (m_stale) begin
            if (br)  m_pc = tgt;
            if (rdy) m_stale = 1'b0;
        end else if (br) begin
            if (!rdy) begin
                m_stale      = 1'b1;
                m_stale_addr = m_pc;
            end
            m_pc = tgt;
        end else if (rdy) begin
            if (hz) begin
                m_held      = 1'b1;
                m_held_word = rd;
                m_held_pc   = m_pc;
            end
            m_pc = m_pc + 32'd4;
        end
        #1;
    endtask

    initial begin
        logic        rdy, hz, br, rs;
        logic [31:0] tgt;

        m_pc = 32'h0; m_stale = 1'b0; m_held = 1'b0;
        m_stale_addr = 32'h0; m_held_word = 32'h0; m_held_pc = 32'h0;
        r2_rst = 1'b1; r2_rdy = 1'b0; r2_word = 32'h0;

        // Reset beats an asserted branch and a ready response.
        step(1'b1, 1'b1, 1'b1, 32'h0000_0500, 1'b1);
        chk("rst_req",   {31'd0, s_req},   32'd0);
        chk("rst_flush", {31'd0, s_flush}, 32'd0);
        chk("rst_instr", s_instr, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Always-ready stream from RESET_PC.
        for (int unsigned i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            chk("seq_pc",   s_pc,   32'(i * 4));
            chk("seq_addr", s_addr, 32'(i * 4));
            chk("seq_instr", s_instr, mem_word(32'(i * 4)));
        end

        // Three-cycle latency at 0x10.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("lat_bubble", s_instr, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("lat_addr", s_addr, 32'h10);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("lat_pc", s_pc, 32'h10);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("lat_next", s_addr, 32'h14);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Hazard on the 0x20 response parks it for two cycles.
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("hz_pc", s_pc, 32'h20);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("hold_req", {31'd0, s_req}, 32'd0);
        chk("hold_instr", s_instr, mem_word(32'h20));
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("hold_pc", s_pc, 32'h20);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("hold_next", s_addr, 32'h24);
        for (int unsigned i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect to 0x100 while 0x40 is outstanding.
        step(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
        chk("drain_flush", {31'd0, s_flush}, 32'd1);
        chk("drain_addr0", s_addr, 32'h40);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("drain_addr1", s_addr, 32'h40);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("drain_discard", s_instr, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("drain_target", s_addr, 32'h100);

        // Branch, ready and hazard together: branch wins, no hold.
        step(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b1);
        chk("bhr_instr", s_instr, 32'h0);
        chk("bhr_flush", {31'd0, s_flush}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("bhr_req", {31'd0, s_req}, 32'd1);
        chk("bhr_addr", s_addr, 32'h200);

        // PC wrap on the primary instance.
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_pc", s_pc, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_zero", s_pc, 32'h0);

        // Second instance: RESET_PC at the top of the address space.
        r2_rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("r2_rst_req", {31'd0, s2_req}, 32'd0);
        r2_rst = 1'b0; r2_rdy = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            r2_word = 32'hC0DE_0000 + 32'(i);
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            chk("r2_pc", s2_pc, 32'hFFFF_FFFC + 32'(i * 4));
            chk("r2_instr", s2_instr, 32'hC0DE_0000 + 32'(i));
        end
        r2_rdy = 1'b0;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("r2_wait_addr", s2_addr, 32'h8);
        chk("r2_wait_instr", s2_instr, 32'h0);
        r2_rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("r2_midrst_req", {31'd0, s2_req}, 32'd0);
        chk("r2_midrst_pc", s2_pc, 32'h0);
        r2_rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("r2_fresh_req", {31'd0, s2_req}, 32'd1);
        chk("r2_fresh_addr", s2_addr, 32'hFFFF_FFFC);

        // Randomized traffic against the model.
        for (int unsigned i = 0; i < 600; i++) begin
            rs  = ($urandom_range(0, 99) < 2);
            br  = ($urandom_range(0, 99) < 12);
            hz  = ($urandom_range(0, 99) < 30);
            rdy = m_held ? 1'b0 : ($urandom_range(0, 99) < 55);
            case ($urandom_range(0, 9))
                0:       tgt = $urandom;
                1:       tgt = 32'hFFFF_FFF8;
                default: tgt = $urandom & 32'h0000_FFFC;
            endcase
            step(rs, hz, br, tgt, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues requests to a variable-latency instruction memory over a req/ready handshake.
- Presents one fetched instruction plus its PC per cycle to IF/ID, or a NOP bubble when no instruction is available.
- Handles hazard stalls and branch redirects, including redirects that arrive while a memory request is outstanding.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
NOP_INSTR, 32'h0000_0000, bubble encoding driven on instr_o (matches IF/ID flush value).

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_i  input  1  synchronous active-high reset.
hazard_i  input  1  downstream stall; IF/ID holds its contents this cycle.
branch_i  input  1  redirect request from ID.
branch_target_i  input  32  redirect PC, valid when branch_i=1.
imem_req_o  output  1  instruction memory request.
imem_addr_o  output  32  request address; stable while imem_req_o=1 and imem_ready_i=0.
imem_ready_i  input  1  memory response strobe; imem_rdata_i valid this cycle.
imem_rdata_i  input  32  fetched instruction.
pc_o  output  32  address of the instruction on instr_o; 0 with a bubble.
instr_o  output  32  instruction to IF/ID, or NOP_INSTR.
flush_o  output  1  IF/ID flush; equals branch_i (combinational).

Behaviour:
- Registers:
  - pc_r: next PC to fetch.
  - addr_r: address of the outstanding request.
  - buf_r, buf_pc_r: held instruction and its PC.
  - state: REQ, HOLD, DRAIN.
- Reset (rst_i=1 at an edge): pc_r=RESET_PC, addr_r=RESET_PC, state=REQ, buffers=0.
  - While rst_i=1, outputs are forced to: imem_req_o=0, instr_o=NOP_INSTR, pc_o=0, flush_o=0.
  - Reset wins over every other input. Reset during an outstanding request abandons it; the memory must tolerate this.
- imem_req_o=1 in REQ and DRAIN. imem_addr_o = pc_r in REQ, addr_r in DRAIN.
- Entering REQ, addr_r <= pc_r. The address is never changed while a request is outstanding.
- REQ:
  - ready=0, branch=0: output bubble; stay in REQ.
  - ready=0, branch=1: pc_r <= target; addr_r keeps the old address; go to DRAIN.
  - ready=1, branch=1: discard rdata; output bubble; pc_r <= target; stay in REQ.
  - ready=1, branch=0, hazard=0: instr_o=rdata, pc_o=pc_r (combinational, zero added latency); pc_r <= pc_r+4; stay in REQ.
  - ready=1, branch=0, hazard=1: drive instr_o=rdata anyway (IF/ID ignores it while stalled); buf_r <= rdata, buf_pc_r <= pc_r; pc_r <= pc_r+4; go to HOLD.
- HOLD (no request issued):
  - Outputs: instr_o=buf_r, pc_o=buf_pc_r.
  - branch=1: discard buffer, output bubble, pc_r <= target, go to REQ.
  - Otherwise, hazard=0: IF/ID consumes the buffer this edge; go to REQ.
  - Otherwise, hazard=1: stay in HOLD.
- DRAIN:
  - Output bubble while waiting for the stale response.
  - branch=1: pc_r <= target (latest target wins).
  - ready=1: response discarded; go to REQ.
- Branch priority: branch_i outranks hazard_i.
- flush_o=branch_i in every non-reset state. Whenever branch_i=1, instr_o is NOP_INSTR.
- Arithmetic: pc_r+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). Low two PC bits are passed through unchecked.
- Throughput: with an always-ready memory and no hazards, one instruction per cycle. PC sequence is RESET_PC, +4, +8, ...

Test Plan:
1. Reset, then imem_ready_i=1 constant, no hazard/branch for 4 cycles -> imem_addr_o and pc_o = 0,4,8,12; instr_o equals rdata each cycle; flush_o=0.
2. 3-cycle memory latency at PC 0x10 -> bubbles (instr_o=0) for 2 cycles; rdata on cycle 3 with pc_o=0x10; next request addr 0x14.
3. Response at PC 0x20 with hazard_i=1 for 2 cycles -> state HOLD, no request, instr_o=buffered word, pc_o=0x20 held; hazard drops -> next request at 0x24.
4. branch_i=1 with target 0x100 while request at 0x40 is outstanding (ready=0) -> flush_o=1; imem_addr_o stays 0x40 until ready; that rdata discarded (instr_o=0); next request addr 0x100.
5. branch_i=1 with target 0x200 in the same cycle as ready=1 and hazard_i=1 -> instr_o=0, flush_o=1, next request 0x200, no HOLD entry.
6. RESET_PC=32'hFFFF_FFFC with an always-ready memory -> pc_o sequence FFFF_FFFC, 0, 4; assert rst_i mid-wait -> imem_req_o=0 that cycle, then a fresh request at RESET_PC.
